// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 max pooling over a square raster-order image.
// One line buffer of IMG_SIZE/2 pair maxima bridges each even row to the following odd row.
module maxpool_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IMG_SIZE   = 126
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  pool_done
);

   localparam int unsigned CW    = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
   localparam int unsigned HALF  = IMG_SIZE / 2;
   localparam int unsigned HW    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned DEPTH = 1 << HW;
   localparam logic [CW-1:0] LAST_IDX  = CW'(IMG_SIZE - 1);
   localparam logic [CW-1:0] LAST_POOL = CW'(2 * HALF - 1);
   localparam bit ODD = (IMG_SIZE % 2) == 1;

   typedef enum logic [1:0] {st_idle, st_run, st_done} state_t;

   state_t                state_q;
   logic [CW-1:0]         col_q;
   logic [CW-1:0]         row_q;
   logic [DATA_WIDTH-1:0] pair_q;
   logic                  out_last_q;
   logic                  in_all_q;
   logic                  out_all_q;
   logic [DATA_WIDTH-1:0] line_mem [DEPTH];

   logic                  xfer;
   logic                  out_xfer;
   logic                  keep;
   logic                  last_px;
   logic                  write_line;
   logic                  load_out;
   logic                  frame_in_done;
   logic                  frame_out_done;
   logic [HW-1:0]         line_idx;
   logic [DATA_WIDTH-1:0] line_rd;
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] win_max;

   assign in_ready = (state_q == st_run) && (!out_valid || out_ready);
   assign xfer     = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // With an odd size the last column and last row fall outside every window.
   assign keep    = !(ODD && ((col_q == LAST_IDX) || (row_q == LAST_IDX)));
   assign last_px = (col_q == LAST_IDX) && (row_q == LAST_IDX);

   assign line_idx = HW'(col_q >> 1);
   assign line_rd  = line_mem[line_idx];
   assign pair_max = (in_data > pair_q) ? in_data : pair_q;
   assign win_max  = (line_rd > pair_max) ? line_rd : pair_max;

   assign write_line = xfer && keep && col_q[0] && !row_q[0];
   assign load_out   = xfer && keep && col_q[0] && row_q[0];

   // Trailing discarded pixels may arrive after the last pooled output has drained.
   assign frame_in_done  = in_all_q || (xfer && last_px);
   assign frame_out_done = out_all_q || (out_xfer && out_last_q);

   assign pool_done = (state_q == st_done);

   always_ff @(posedge clk) begin
      if (write_line) begin
         line_mem[line_idx] <= pair_max;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= st_idle;
         col_q      <= '0;
         row_q      <= '0;
         pair_q     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last_q <= 1'b0;
         in_all_q   <= 1'b0;
         out_all_q  <= 1'b0;
      end else begin
         if (xfer) begin
            if (col_q == LAST_IDX) begin
               col_q <= '0;
               row_q <= (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
            if (keep && !col_q[0]) begin
               pair_q <= in_data;
            end
         end

         if (load_out) begin
            out_data   <= win_max;
            out_valid  <= 1'b1;
            out_last_q <= (row_q == LAST_POOL) && (col_q == LAST_POOL);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state_q)
            st_idle: begin
               if (en) begin
                  state_q <= st_run;
               end
            end
            st_run: begin
               if (frame_in_done && frame_out_done) begin
                  state_q   <= st_done;
                  in_all_q  <= 1'b0;
                  out_all_q <= 1'b0;
               end else begin
                  in_all_q  <= frame_in_done;
                  out_all_q <= frame_out_done;
               end
            end
            st_done: begin
               if (!en) begin
                  state_q <= st_idle;
               end
            end
            default: state_q <= st_idle;
         endcase
      end
   end

endmodule
